rx_deinterleaver_ctrl_wifi: RTL
===============================

// Module: rx_deinterleaver_ctrl_wifi
// PURPOSE
//  Symbol sequencer for the WIFI RX deinterleaver (N_CBPS = 48/96/192 variants).
//  Gates the serial demapper bit stream into the deinterleaver one OFDM symbol at a time.
//  Stalls upstream while a symbol drains and counts symbols up to a programmed frame length.
//  Reports frame completion, overrun and drain-timeout errors.
// PARAMETERS
//  N_CBPS         96    coded bits per OFDM symbol; one of 48, 96, 192
//  SYM_W          10    width of the symbol count / frame length
//  DRAIN_TIMEOUT  1024  max cycles in DRAIN waiting for dil_finished before error
// PORTS
//  clk            in   1      single clock, rising edge
//  reset          in   1      synchronous, active-high
//  start          in   1      pulse; begins frame (honoured only in IDLE)
//  abort          in   1      pulse; return to IDLE from any state
//  num_symbols    in   SYM_W  frame length in symbols, latched on accepted start
//  bit_valid_in   in   1      upstream demapper bit valid
//  bit_in         in   1      upstream demapper bit
//  bit_ready      out  1      controller accepts bit this cycle
//  dil_enable     out  1      to deinterleaver enable
//  dil_valid_in   out  1      to deinterleaver valid_in
//  dil_data_in    out  1      to deinterleaver data_in
//  dil_finished   in   1      from deinterleaver; 1-cycle pulse at symbol drain end
//  busy           out  1      high in any state except IDLE
//  sym_count      out  SYM_W  symbols completed in current frame
//  frame_done     out  1      1-cycle pulse at successful frame end
//  overrun        out  1      sticky; bit_valid_in seen while bit_ready=0 and busy
//  timeout_err    out  1      sticky; DRAIN exceeded DRAIN_TIMEOUT
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; internal counters 0.
//  FSM states: IDLE, LOAD, DRAIN, DONE.
//  IDLE:
//   - start=1 latches num_symbols; clears sym_count, overrun and timeout_err.
//   - Latched value 0 -> DONE, else -> LOAD. start in any other state is ignored.
//  LOAD:
//   - bit_ready=1, dil_enable=1.
//   - Accepted bit (bit_valid_in&bit_ready) is registered: dil_valid_in/dil_data_in
//     follow 1 cycle later (latency 1).
//   - bit_cnt 0..N_CBPS-1 counts accepted bits; on the accept at N_CBPS-1 -> DRAIN,
//     bit_cnt wraps to 0.
//  DRAIN:
//   - bit_ready=0, dil_enable=1, dil_valid_in=0 after the last registered bit.
//   - Wait cycle counter runs while waiting for dil_finished.
//   - dil_finished=1: sym_count+1; if the new sym_count==num_symbols -> DONE, else -> LOAD.
//   - Counter reaching DRAIN_TIMEOUT without dil_finished:
//     timeout_err=1, -> IDLE, dil_enable=0.
//   - dil_finished outside DRAIN is ignored.
//  DONE: frame_done=1 for exactly one cycle, dil_enable=0, -> IDLE.
//  overrun:
//   - Set when bit_valid_in=1 in DRAIN or DONE; the bit is dropped, not queued.
//   - Held until next accepted start or reset.
//  abort:
//   - Priority over all transitions except reset; -> IDLE next cycle.
//   - dil_enable, dil_valid_in and bit_ready go 0; bit_cnt cleared.
//   - sym_count and the sticky flags are held.
//  reset mid-frame: immediate return to reset values; no frame_done.
//  Simultaneous dil_finished and timeout in the same cycle: dil_finished wins.
// TESTING
//  T1 N_CBPS=96, num_symbols=2, continuous bit_valid_in
//     -> 96 dil_valid_in per symbol, 1-cycle latency; sym_count 1 then 2;
//        one frame_done pulse; busy falls after DONE.
//  T2 num_symbols=0, start
//     -> DONE the next cycle, frame_done pulse, no dil_valid_in.
//  T3 bit_valid_in held high during DRAIN
//     -> bit_ready=0, overrun=1 sticky; dil_data_in unaffected; cleared on next start.
//  T4 dil_finished withheld 1024 cycles
//     -> timeout_err=1, state IDLE, dil_enable=0, no frame_done.
//  T5 abort after 40 bits of symbol 1; then start num_symbols=1
//     -> IDLE; the new frame loads exactly 96 bits from bit_cnt=0.
//  T6 reset asserted in LOAD; start pulsed while busy
//     -> all outputs 0 after reset; start while busy has no effect on num_symbols.

Source files
------------

// File: rtl/rx_deinterleaver_ctrl_wifi.sv
// Symbol sequencer for the WIFI RX deinterleaver.
// Gates the serial demapper bit stream into the deinterleaver one OFDM symbol
// (N_CBPS coded bits) at a time. It stalls upstream while a symbol drains and
// counts symbols up to a frame length latched at start. It also flags frame
// completion, dropped bits (overrun) and a deinterleaver that never finishes
// draining (timeout_err).
module rx_deinterleaver_ctrl_wifi #(
  parameter int N_CBPS        = 96,
  parameter int SYM_W         = 10,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [SYM_W-1:0] num_symbols,
  input  logic             bit_valid_in,
  input  logic             bit_in,
  output logic             bit_ready,
  output logic             dil_enable,
  output logic             dil_valid_in,
  output logic             dil_data_in,
  input  logic             dil_finished,
  output logic             busy,
  output logic [SYM_W-1:0] sym_count,
  output logic             frame_done,
  output logic             overrun,
  output logic             timeout_err
);

  localparam int CNT_W  = (N_CBPS > 1) ? $clog2(N_CBPS) : 1;
  localparam int WAIT_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(N_CBPS - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [SYM_W-1:0]  num_lat;
  logic [SYM_W-1:0]  sym_next;
  logic              accept;

  // A bit is taken only when we advertise ready; everything else is dropped.
  assign accept   = bit_valid_in & bit_ready;
  assign sym_next = sym_count + 1'b1;

  // Sequencer FSM; every output is a register that is written alongside the
  // state transition that implies it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      wait_cnt     <= '0;
      num_lat      <= '0;
      sym_count    <= '0;
      bit_ready    <= 1'b0;
      dil_enable   <= 1'b0;
      dil_valid_in <= 1'b0;
      dil_data_in  <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else if (abort) begin
      // Abort drops back to IDLE but keeps sym_count and sticky flags for inspection.
      state        <= IDLE;
      bit_cnt      <= '0;
      wait_cnt     <= '0;
      bit_ready    <= 1'b0;
      dil_enable   <= 1'b0;
      dil_valid_in <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      dil_valid_in <= 1'b0;
      frame_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            num_lat     <= num_symbols;
            sym_count   <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
            bit_cnt     <= '0;
            busy        <= 1'b1;
            if (num_symbols == '0) begin
              // Empty frame completes immediately without touching the deinterleaver.
              state      <= DONE;
              frame_done <= 1'b1;
            end else begin
              state      <= LOAD;
              bit_ready  <= 1'b1;
              dil_enable <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            dil_valid_in <= 1'b1;
            dil_data_in  <= bit_in;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt   <= '0;
              wait_cnt  <= '0;
              state     <= DRAIN;
              bit_ready <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (bit_valid_in) begin
            overrun <= 1'b1;
          end
          // A finish arriving on the last allowed cycle still counts as success.
          if (dil_finished) begin
            sym_count <= sym_next;
            wait_cnt  <= '0;
            if (sym_next == num_lat) begin
              state      <= DONE;
              dil_enable <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              state     <= LOAD;
              bit_ready <= 1'b1;
            end
          end else if (wait_cnt == LAST_WAIT) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
            dil_enable  <= 1'b0;
            busy        <= 1'b0;
            wait_cnt    <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          if (bit_valid_in) begin
            overrun <= 1'b1;
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
